// File: rtl/rng_stream_fifo.sv
// ============================================================================
// Module   : rng_stream_fifo
// Purpose  : TRNG word buffer with first-word-fall-through AXI4-Stream master
//            output, occupancy/overflow status and completed-transfer count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rng_stream_fifo #(
  parameter int ADDR_W = 9
) (
  input  logic              CLK,
  input  logic              RST_X,
  input  logic              FLUSH,
  input  logic [32:0]       WR_DATA,
  input  logic              WR_EN,
  output logic              FULL,
  output logic [31:0]       M_AXIS_TDATA,
  output logic              M_AXIS_TLAST,
  output logic              M_AXIS_TVALID,
  input  logic              M_AXIS_TREADY,
  output logic [ADDR_W:0]   LEVEL,
  output logic              OVERFLOW,
  output logic [31:0]       XFER_CNT
);

  localparam int c_DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] c_PTR_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] c_FULL_XOR = {1'b1, {ADDR_W{1'b0}}};

  logic [32:0]     r_mem [c_DEPTH];
  logic [ADDR_W:0] r_wp;
  logic [ADDR_W:0] r_rp;
  logic [31:0]     r_tdata;
  logic            r_tlast;
  logic            r_tvalid;
  logic            r_overflow;
  logic [31:0]     r_xfer_cnt;

  logic [ADDR_W:0] w_mcount;
  logic            w_empty;
  logic            w_full;
  logic            w_wr;
  logic            w_wr_mem;
  logic            w_load;
  logic            w_accept;
  logic [32:0]     w_rd_word;

  // Status is derived purely from registered pointers so the controller and
  // this block always agree on whether a given write was dropped.
  assign w_mcount  = r_wp - r_rp;
  assign w_empty   = (r_wp == r_rp);
  assign w_full    = ((r_wp ^ r_rp) == c_FULL_XOR);
  assign w_wr      = WR_EN && !w_full;
  assign w_wr_mem  = w_wr && RST_X && !FLUSH;
  assign w_accept  = r_tvalid && M_AXIS_TREADY;
  assign w_load    = !w_empty && (!r_tvalid || M_AXIS_TREADY);
  assign w_rd_word = r_mem[r_rp[ADDR_W-1:0]];

  always_ff @(posedge CLK) begin
    if (w_wr_mem) begin
      r_mem[r_wp[ADDR_W-1:0]] <= WR_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_tdata    <= '0;
      r_tlast    <= 1'b0;
      r_tvalid   <= 1'b0;
      r_overflow <= 1'b0;
      r_xfer_cnt <= '0;
    end else if (FLUSH) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_tvalid   <= 1'b0;
      r_overflow <= 1'b0;
      r_xfer_cnt <= '0;
    end else begin
      if (w_wr) begin
        r_wp <= r_wp + c_PTR_ONE;
      end
      if (WR_EN && w_full) begin
        r_overflow <= 1'b1;
      end
      // Output register only changes on load, keeping data stable under stall.
      if (w_load) begin
        r_tlast  <= w_rd_word[32];
        r_tdata  <= w_rd_word[31:0];
        r_rp     <= r_rp + c_PTR_ONE;
        r_tvalid <= 1'b1;
      end else if (w_accept) begin
        r_tvalid <= 1'b0;
      end
      if (w_accept && r_tlast) begin
        r_xfer_cnt <= r_xfer_cnt + 32'd1;
      end
    end
  end

  assign FULL          = w_full;
  assign M_AXIS_TDATA  = r_tdata;
  assign M_AXIS_TLAST  = r_tlast;
  assign M_AXIS_TVALID = r_tvalid;
  assign LEVEL         = w_mcount + {{ADDR_W{1'b0}}, r_tvalid};
  assign OVERFLOW      = r_overflow;
  assign XFER_CNT      = r_xfer_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rng_stream_fifo.sv
// ============================================================================
// Module   : tb_rng_stream_fifo
// Purpose  : Scoreboard bench for rng_stream_fifo with a 16-word memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rng_stream_fifo;

  localparam int AW = 4;

  logic          CLK;
  logic          RST_X;
  logic          FLUSH;
  logic [32:0]   WR_DATA;
  logic          WR_EN;
  logic          FULL;
  logic [31:0]   M_AXIS_TDATA;
  logic          M_AXIS_TLAST;
  logic          M_AXIS_TVALID;
  logic          M_AXIS_TREADY;
  logic [AW:0]   LEVEL;
  logic          OVERFLOW;
  logic [31:0]   XFER_CNT;

  int checks   = 0;
  int failures = 0;
  logic [32:0] exp_q[$];

  rng_stream_fifo #(.ADDR_W(AW)) dut (
    .CLK           (CLK),
    .RST_X         (RST_X),
    .FLUSH         (FLUSH),
    .WR_DATA       (WR_DATA),
    .WR_EN         (WR_EN),
    .FULL          (FULL),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .LEVEL         (LEVEL),
    .OVERFLOW      (OVERFLOW),
    .XFER_CNT      (XFER_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_flush();
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    RST_X = 1'b0;
    tick();
    tick();
    RST_X = 1'b1;
    tick();
    checks++; if (M_AXIS_TVALID !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%0b exp=0", M_AXIS_TVALID); end
    checks++; if (M_AXIS_TDATA !== 32'd0) begin failures++; $display("FAIL reset_tdata got=%h exp=0", M_AXIS_TDATA); end
    checks++; if (M_AXIS_TLAST !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%0b exp=0", M_AXIS_TLAST); end
    checks++; if (FULL !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", FULL); end
    checks++; if (LEVEL !== '0) begin failures++; $display("FAIL reset_level got=%0d exp=0", LEVEL); end
    checks++; if (OVERFLOW !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", OVERFLOW); end
    checks++; if (XFER_CNT !== 32'd0) begin failures++; $display("FAIL reset_xfer got=%0d exp=0", XFER_CNT); end
  endtask

  task automatic test_single();
    M_AXIS_TREADY = 1'b1;
    WR_DATA = 33'h1_DEADBEEF;
    WR_EN = 1'b1;
    tick();
    WR_EN = 1'b0;
    checks++; if (M_AXIS_TVALID !== 1'b0) begin failures++; $display("FAIL single_no_bypass got=%0b exp=0", M_AXIS_TVALID); end
    checks++; if (LEVEL !== 5'd1) begin failures++; $display("FAIL single_level_mem got=%0d exp=1", LEVEL); end
    tick();
    checks++; if (M_AXIS_TVALID !== 1'b1) begin failures++; $display("FAIL single_tvalid got=%0b exp=1", M_AXIS_TVALID); end
    checks++; if ({M_AXIS_TLAST, M_AXIS_TDATA} !== 33'h1_DEADBEEF) begin failures++; $display("FAIL single_data got=%h exp=1deadbeef", {M_AXIS_TLAST, M_AXIS_TDATA}); end
    tick();
    checks++; if (XFER_CNT !== 32'd1) begin failures++; $display("FAIL single_xfer got=%0d exp=1", XFER_CNT); end
    checks++; if (LEVEL !== '0) begin failures++; $display("FAIL single_level_end got=%0d exp=0", LEVEL); end
    checks++; if (M_AXIS_TVALID !== 1'b0) begin failures++; $display("FAIL single_drain got=%0b exp=0", M_AXIS_TVALID); end
  endtask

  task automatic test_fill_overflow();
    logic [32:0] got;
    int cyc;
    do_flush();
    M_AXIS_TREADY = 1'b0;
    for (int i = 0; i < 17; i++) begin
      WR_DATA = {1'b0, 32'hA000_0000 + 32'(i)};
      WR_EN = 1'b1;
      exp_q.push_back(WR_DATA);
      tick();
    end
    WR_EN = 1'b0;
    checks++; if (FULL !== 1'b1) begin failures++; $display("FAIL fill_full got=%0b exp=1", FULL); end
    checks++; if (LEVEL !== 5'd17) begin failures++; $display("FAIL fill_level got=%0d exp=17", LEVEL); end
    checks++; if (OVERFLOW !== 1'b0) begin failures++; $display("FAIL fill_ovf_early got=%0b exp=0", OVERFLOW); end
    WR_DATA = 33'h1_BADBAD00;
    WR_EN = 1'b1;
    tick();
    WR_EN = 1'b0;
    checks++; if (OVERFLOW !== 1'b1) begin failures++; $display("FAIL fill_overflow got=%0b exp=1", OVERFLOW); end
    checks++; if (LEVEL !== 5'd17) begin failures++; $display("FAIL fill_level_after_drop got=%0d exp=17", LEVEL); end
    M_AXIS_TREADY = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 100) begin
      if (M_AXIS_TVALID) begin
        got = {M_AXIS_TLAST, M_AXIS_TDATA};
        checks++; if (got !== exp_q[0]) begin failures++; $display("FAIL fill_drain_data got=%h exp=%h", got, exp_q[0]); end
        void'(exp_q.pop_front());
      end
      tick();
      cyc++;
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL fill_drain_timeout got=%0d left exp=0", exp_q.size()); end
    tick();
    checks++; if (M_AXIS_TVALID !== 1'b0) begin failures++; $display("FAIL fill_dropped_word_seen got=%0b exp=0", M_AXIS_TVALID); end
  endtask

  // Writer feeds whenever FULL is low; every accepted beat is matched against
  // the scoreboard and stalled beats must hold their value.
  task automatic test_stream(input int n, input int last_every, input bit rand_ready, input bit b2b);
    logic [32:0] got, held;
    bit stalled;
    int sent, cyc;
    do_flush();
    sent = 0; cyc = 0; stalled = 0; held = '0;
    while ((sent < n || exp_q.size() > 0) && cyc < n * 4 + 200) begin
      got = {M_AXIS_TLAST, M_AXIS_TDATA};
      if (stalled) begin
        checks++; if (M_AXIS_TVALID !== 1'b1 || got !== held) begin failures++; $display("FAIL stream_stall_stable got=%h v=%0b exp=%h", got, M_AXIS_TVALID, held); end
      end
      if (b2b) begin
        checks++; if (FULL !== 1'b0) begin failures++; $display("FAIL stream_full_asserted got=%0b exp=0", FULL); end
        if (cyc > 2 && sent < n) begin
          checks++; if (LEVEL < 5'd1 || LEVEL > 5'd2) begin failures++; $display("FAIL stream_b2b_level got=%0d exp=1..2", LEVEL); end
        end
      end
      M_AXIS_TREADY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        if (exp_q.size() == 0) begin
          checks++; failures++; $display("FAIL stream_unexpected_beat got=%h exp=none", got);
        end else begin
          checks++; if (got !== exp_q[0]) begin failures++; $display("FAIL stream_data got=%h exp=%h", got, exp_q[0]); end
          void'(exp_q.pop_front());
        end
      end
      if (sent < n && !FULL) begin
        WR_DATA = {(last_every > 0) && ((sent % last_every) == last_every - 1), 32'h5000_0000 + 32'(sent)};
        WR_EN = 1'b1;
        exp_q.push_back(WR_DATA);
        sent++;
      end else begin
        WR_EN = 1'b0;
      end
      stalled = M_AXIS_TVALID && !M_AXIS_TREADY;
      held = got;
      tick();
      cyc++;
    end
    WR_EN = 1'b0;
    M_AXIS_TREADY = 1'b0;
    checks++; if (sent != n || exp_q.size() != 0) begin failures++; $display("FAIL stream_complete got=sent %0d left %0d exp=sent %0d left 0", sent, exp_q.size(), n); end
  endtask

  task automatic test_tlast();
    test_stream(4096, 64, 1'b1, 1'b0);
    checks++; if (XFER_CNT !== 32'd64) begin failures++; $display("FAIL tlast_xfer_cnt got=%0d exp=64", XFER_CNT); end
  endtask

  task automatic test_wrap();
    test_stream(1000, 0, 1'b0, 1'b1);
    checks++; if (LEVEL !== '0) begin failures++; $display("FAIL wrap_level_end got=%0d exp=0", LEVEL); end
  endtask

  task automatic test_flush();
    do_flush();
    M_AXIS_TREADY = 1'b1;
    WR_DATA = 33'h1_00000001;
    WR_EN = 1'b1;
    tick();
    WR_EN = 1'b0;
    tick();
    tick();
    checks++; if (XFER_CNT !== 32'd1) begin failures++; $display("FAIL flush_pre_xfer got=%0d exp=1", XFER_CNT); end
    M_AXIS_TREADY = 1'b0;
    for (int i = 0; i < 18; i++) begin
      WR_DATA = {1'b0, 32'hC000_0000 + 32'(i)};
      WR_EN = 1'b1;
      tick();
    end
    WR_EN = 1'b0;
    M_AXIS_TREADY = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    M_AXIS_TREADY = 1'b0;
    checks++; if (LEVEL !== 5'd10 || OVERFLOW !== 1'b1) begin failures++; $display("FAIL flush_pre_state got=level %0d ovf %0b exp=level 10 ovf 1", LEVEL, OVERFLOW); end
    FLUSH = 1'b1;
    WR_EN = 1'b1;
    WR_DATA = 33'h0_FFFF0000;
    tick();
    FLUSH = 1'b0;
    WR_EN = 1'b0;
    checks++; if (LEVEL !== '0) begin failures++; $display("FAIL flush_level got=%0d exp=0", LEVEL); end
    checks++; if (M_AXIS_TVALID !== 1'b0) begin failures++; $display("FAIL flush_tvalid got=%0b exp=0", M_AXIS_TVALID); end
    checks++; if (OVERFLOW !== 1'b0) begin failures++; $display("FAIL flush_overflow got=%0b exp=0", OVERFLOW); end
    checks++; if (XFER_CNT !== 32'd0) begin failures++; $display("FAIL flush_xfer got=%0d exp=0", XFER_CNT); end
    checks++; if (FULL !== 1'b0) begin failures++; $display("FAIL flush_full got=%0b exp=0", FULL); end
    WR_DATA = 33'h0_12345678;
    WR_EN = 1'b1;
    M_AXIS_TREADY = 1'b1;
    tick();
    WR_EN = 1'b0;
    tick();
    checks++; if (M_AXIS_TVALID !== 1'b1 || {M_AXIS_TLAST, M_AXIS_TDATA} !== 33'h0_12345678) begin failures++; $display("FAIL flush_next_word got=%h v=%0b exp=012345678", {M_AXIS_TLAST, M_AXIS_TDATA}, M_AXIS_TVALID); end
    tick();
    M_AXIS_TREADY = 1'b0;
  endtask

  task automatic test_reset_mid();
    M_AXIS_TREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      WR_DATA = {1'b1, 32'(i)};
      WR_EN = 1'b1;
      tick();
    end
    WR_EN = 1'b0;
    RST_X = 1'b0;
    tick();
    RST_X = 1'b1;
    checks++; if (LEVEL !== '0 || M_AXIS_TVALID !== 1'b0) begin failures++; $display("FAIL midreset_state got=level %0d v=%0b exp=level 0 v=0", LEVEL, M_AXIS_TVALID); end
    M_AXIS_TREADY = 1'b1;
    tick();
    tick();
    checks++; if (M_AXIS_TVALID !== 1'b0 || XFER_CNT !== 32'd0) begin failures++; $display("FAIL midreset_no_data got=v %0b xfer %0d exp=v 0 xfer 0", M_AXIS_TVALID, XFER_CNT); end
  endtask

  initial begin
    RST_X = 1'b0;
    FLUSH = 1'b0;
    WR_EN = 1'b0;
    WR_DATA = '0;
    M_AXIS_TREADY = 1'b0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_stream(10000, 0, 1'b1, 1'b0);
    test_tlast();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
